// File: rtl/multi_ch_pattern_gen_pkg.sv
// Shared types and constants for the multi-channel pattern generator.
package multi_ch_pattern_pkg;

    // Command field of the control byte
    typedef enum logic [1:0] {
        CMD_LOAD  = 2'b00,
        CMD_START = 2'b01,
        CMD_STOP  = 2'b10,
        CMD_NONE  = 2'b11
    } cmd_e;

    // Control byte field positions
    localparam int CTRL_CH_HI   = 7;
    localparam int CTRL_CH_LO   = 4;
    localparam int CTRL_IDLE    = 3;
    localparam int CTRL_MODE    = 2;
    localparam int CTRL_CMD_HI  = 1;
    localparam int CTRL_CMD_LO  = 0;

    // Channel state
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    // Bytes per packet: out pattern, freq pattern, control byte
    function automatic int pack_num(input int data_bit);
        return 2 * data_bit / 8 + 1;
    endfunction

endpackage

// File: rtl/multi_ch_pattern_gen_ch_runner.sv
// One output channel: shadow/active pattern registers, pending restart,
// per-bit divider and bit counter, IDLE/RUN state machine.
module pattern_ch_runner
    import multi_ch_pattern_pkg::*;
#(
    parameter int DATA_BIT = 32,
    parameter int LOW_DIV  = 20,
    parameter int HIGH_DIV = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [DATA_BIT-1:0] wr_out,
    input  logic [DATA_BIT-1:0] wr_freq,
    input  logic                wr_idle,
    input  logic                wr_mode,
    input  cmd_e                wr_cmd,
    output logic                serial_out,
    output logic                bit_tick,
    output logic                done_tick,
    output logic                busy
);

    localparam int DIV_MAX = (LOW_DIV > HIGH_DIV) ? LOW_DIV : HIGH_DIV;
    localparam int DIV_W   = $clog2(DIV_MAX);
    localparam int BIT_W   = $clog2(DATA_BIT);
    localparam logic [DIV_W-1:0] LOW_LAST  = DIV_W'(LOW_DIV - 1);
    localparam logic [DIV_W-1:0] HIGH_LAST = DIV_W'(HIGH_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BIT - 1);

    ch_state_e             state_q, state_d;
    logic [DATA_BIT-1:0]   sh_out, sh_freq, act_out, act_freq;
    logic                  sh_idle, sh_mode, act_idle, act_mode;
    logic                  pending, done_q;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  start_cmd, stop_cmd, bit_end, pat_end, copy;
    logic [DATA_BIT-1:0]   src_out, src_freq;
    logic                  src_idle, src_mode;

    // Command decode, bit/pattern boundaries and copy source selection
    always_comb begin
        start_cmd = wr_en && (wr_cmd == CMD_START);
        stop_cmd  = wr_en && (wr_cmd == CMD_STOP);
        bit_end   = (state_q == RUN) &&
                    (div_cnt == (act_freq[bit_cnt] ? HIGH_LAST : LOW_LAST));
        pat_end   = bit_end && (bit_cnt == BIT_LAST);
        // a start arriving on the boundary cycle itself behaves like a pending one
        copy      = ((state_q == IDLE) && start_cmd) ||
                    ((state_q == RUN) && !stop_cmd && pat_end && (pending || start_cmd));
        // shadow written this cycle is newer than the registered shadow
        src_out   = wr_en ? wr_out  : sh_out;
        src_freq  = wr_en ? wr_freq : sh_freq;
        src_idle  = wr_en ? wr_idle : sh_idle;
        src_mode  = wr_en ? wr_mode : sh_mode;
    end

    // State register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_cmd) state_d = RUN;
            RUN: begin
                if (stop_cmd)
                    state_d = IDLE;
                else if (pat_end && !pending && !start_cmd && !act_mode)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pattern registers, pending flag, divider and bit counter
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sh_out   <= '0;
            sh_freq  <= '0;
            sh_idle  <= 1'b0;
            sh_mode  <= 1'b0;
            act_out  <= '0;
            act_freq <= '0;
            act_idle <= 1'b0;
            act_mode <= 1'b0;
            pending  <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            done_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                sh_out  <= wr_out;
                sh_freq <= wr_freq;
                sh_idle <= wr_idle;
                sh_mode <= wr_mode;
            end
            if (copy) begin
                act_out  <= src_out;
                act_freq <= src_freq;
                act_mode <= src_mode;
                act_idle <= src_idle;
            end else if (stop_cmd || (wr_en && (state_q == IDLE))) begin
                act_idle <= wr_idle;
            end
            if (copy || stop_cmd)
                pending <= 1'b0;
            else if (start_cmd && (state_q == RUN))
                pending <= 1'b1;
            if (copy || (state_q != RUN)) begin
                div_cnt <= '0;
                bit_cnt <= '0;
            end else if (bit_end) begin
                div_cnt <= '0;
                bit_cnt <= pat_end ? '0 : bit_cnt + BIT_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            done_q <= (state_q == RUN) && (state_d == IDLE) && !stop_cmd;
        end
    end

    // Channel outputs
    always_comb begin
        busy       = (state_q == RUN);
        serial_out = (state_q == RUN) ? act_out[bit_cnt] : act_idle;
        bit_tick   = (state_q == RUN) && (div_cnt == '0);
        done_tick  = done_q;
    end

endmodule

// File: rtl/multi_ch_pattern_gen.sv
// Multi-channel pattern generator: UART packet assembler with timeout,
// channel decode, and CH_NUM independent pattern runners.
module multi_ch_pattern_gen
    import multi_ch_pattern_pkg::*;
#(
    parameter int DATA_BIT = 32,
    parameter int CH_NUM   = 16,
    parameter int LOW_DIV  = 20,
    parameter int HIGH_DIV = 5,
    parameter int TIMEOUT  = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        i_data,
    input  logic              i_rx_done_tick,
    output logic [CH_NUM-1:0] o_serial_out,
    output logic [CH_NUM-1:0] o_bit_tick,
    output logic [CH_NUM-1:0] o_done_tick,
    output logic [CH_NUM-1:0] o_busy,
    output logic              o_pkt_err
);

    localparam int PACK_NUM = pack_num(DATA_BIT);
    localparam int CNT_W    = $clog2(PACK_NUM);
    localparam int TMR_W    = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0]      byte_cnt;
    logic [TMR_W-1:0]      timer;
    logic [2*DATA_BIT-1:0] pat_buf;
    logic                  timeout_hit, last_byte, ch_ok;
    logic [3:0]            ctrl_ch;
    logic [CH_NUM-1:0]     wr_en;
    logic [DATA_BIT-1:0]   wr_out, wr_freq;
    logic                  wr_idle, wr_mode;
    cmd_e                  wr_cmd;

    // Timeout detection and final-byte/channel decode
    always_comb begin
        timeout_hit = (byte_cnt != '0) && (timer == TMR_W'(TIMEOUT));
        // a byte on the expiry cycle starts a fresh packet, so never counts as final
        last_byte   = i_rx_done_tick && !timeout_hit && (byte_cnt == CNT_W'(PACK_NUM - 1));
        ctrl_ch     = i_data[CTRL_CH_HI:CTRL_CH_LO];
        ch_ok       = int'(ctrl_ch) < CH_NUM;
    end

    // Byte counter, inter-byte timer and pattern shift buffer
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            byte_cnt <= '0;
            timer    <= '0;
            pat_buf  <= '0;
        end else begin
            if (timeout_hit)
                byte_cnt <= i_rx_done_tick ? CNT_W'(1) : '0;
            else if (i_rx_done_tick)
                byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
            if (i_rx_done_tick || timeout_hit)
                timer <= '0;
            else if (byte_cnt != '0)
                timer <= timer + TMR_W'(1);
            // bytes enter at the top, so the first byte ends up in bits [7:0]
            if (i_rx_done_tick && !last_byte)
                pat_buf <= {i_data, pat_buf[2*DATA_BIT-1:8]};
        end
    end

    // Channel write strobe, payload and packet error pulse
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_en     <= '0;
            wr_out    <= '0;
            wr_freq   <= '0;
            wr_idle   <= 1'b0;
            wr_mode   <= 1'b0;
            wr_cmd    <= CMD_LOAD;
            o_pkt_err <= 1'b0;
        end else begin
            wr_en     <= '0;
            o_pkt_err <= timeout_hit;
            if (last_byte) begin
                if (ch_ok) wr_en <= CH_NUM'(1) << ctrl_ch;
                else       o_pkt_err <= 1'b1;
                wr_out  <= pat_buf[DATA_BIT-1:0];
                wr_freq <= pat_buf[2*DATA_BIT-1:DATA_BIT];
                wr_idle <= i_data[CTRL_IDLE];
                wr_mode <= i_data[CTRL_MODE];
                wr_cmd  <= cmd_e'(i_data[CTRL_CMD_HI:CTRL_CMD_LO]);
            end
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        pattern_ch_runner #(
            .DATA_BIT (DATA_BIT),
            .LOW_DIV  (LOW_DIV),
            .HIGH_DIV (HIGH_DIV)
        ) u_runner (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (wr_en[g]),
            .wr_out     (wr_out),
            .wr_freq    (wr_freq),
            .wr_idle    (wr_idle),
            .wr_mode    (wr_mode),
            .wr_cmd     (wr_cmd),
            .serial_out (o_serial_out[g]),
            .bit_tick   (o_bit_tick[g]),
            .done_tick  (o_done_tick[g]),
            .busy       (o_busy[g])
        );
    end

endmodule

// File: tb/tb_multi_ch_pattern_gen.sv
// Scoreboard bench for multi_ch_pattern_gen: stimulus pushes expected bit and
// done events with absolute cycle numbers; a monitor pops and compares them.
module tb_multi_ch_pattern_gen;

    localparam int DB  = 32;
    localparam int CHN = 4;
    localparam int LD  = 4;
    localparam int HD  = 2;
    localparam int TO  = 200;
    localparam int PN  = 2 * DB / 8 + 1;
    localparam int unsigned HORIZON = 6000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [7:0]     i_data = '0;
    logic           i_rx_done_tick = 1'b0;
    logic [CHN-1:0] o_serial_out, o_bit_tick, o_done_tick, o_busy;
    logic           o_pkt_err;

    multi_ch_pattern_gen #(
        .DATA_BIT (DB),
        .CH_NUM   (CHN),
        .LOW_DIV  (LD),
        .HIGH_DIV (HD),
        .TIMEOUT  (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_data         (i_data),
        .i_rx_done_tick (i_rx_done_tick),
        .o_serial_out   (o_serial_out),
        .o_bit_tick     (o_bit_tick),
        .o_done_tick    (o_done_tick),
        .o_busy         (o_busy),
        .o_pkt_err      (o_pkt_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          ch;
        int unsigned cyc;
        bit          is_done;
        bit          val;
    } ev_t;

    typedef struct {
        int unsigned lo;
        int unsigned hi;
    } err_t;

    ev_t  sb[$];
    err_t eq[$];
    int   compared = 0;
    int   mismatched = 0;

    // reference model: per channel, start cycle and length of the scheduled period
    int unsigned m_start[CHN];
    int unsigned m_len[CHN];
    bit          m_mode[CHN];
    bit          m_act[CHN];
    bit          m_idle[CHN];

    task automatic chk(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int unsigned plen(input logic [DB-1:0] f);
        int unsigned s = 0;
        for (int i = 0; i < DB; i++) s += f[i] ? HD : LD;
        return s;
    endfunction

    function automatic bit running(input int c, input int unsigned t);
        return m_act[c] && (m_mode[c] || (m_start[c] + m_len[c] >= t + 2));
    endfunction

    function automatic logic [CHN-1:0] idle_vec();
        logic [CHN-1:0] v;
        for (int c = 0; c < CHN; c++) v[c] = m_idle[c];
        return v;
    endfunction

    task automatic purge(input int c, input int unsigned from);
        for (int k = sb.size() - 1; k >= 0; k--)
            if (sb[k].ch == c && sb[k].cyc >= from) sb.delete(k);
    endtask

    task automatic push_pat(input int c, input int unsigned st, input logic [DB-1:0] o,
                            input logic [DB-1:0] f, input bit mode, input bit idle);
        int unsigned t = st;
        ev_t e;
        do begin
            for (int i = 0; i < DB; i++) begin
                e.ch = c; e.cyc = t; e.is_done = 1'b0; e.val = o[i];
                sb.push_back(e);
                t += f[i] ? HD : LD;
            end
        end while (mode && t < st + HORIZON);
        if (!mode) begin
            e.ch = c; e.cyc = t; e.is_done = 1'b1; e.val = idle;
            sb.push_back(e);
        end
    endtask

    // apply a packet whose final byte was strobed in cycle t
    task automatic model_cmd(input logic [DB-1:0] o, input logic [DB-1:0] f,
                             input logic [7:0] ctrl, input int unsigned t);
        int c = int'(ctrl[7:4]);
        bit run;
        int unsigned b;
        err_t er;
        if (c >= CHN) begin
            er.lo = t + 1; er.hi = t + 1;
            eq.push_back(er);
            return;
        end
        run = running(c, t);
        case (ctrl[1:0])
            2'b01: begin
                b = t + 2;
                if (run) begin
                    b = m_start[c];
                    if (b < t + 2) begin
                        if (m_mode[c]) while (b < t + 2) b += m_len[c];
                        else b += m_len[c];
                    end
                    purge(c, b);
                end
                push_pat(c, b, o, f, ctrl[2], ctrl[3]);
                m_start[c] = b; m_len[c] = plen(f); m_mode[c] = ctrl[2];
                m_act[c] = 1'b1; m_idle[c] = ctrl[3];
            end
            2'b10: begin
                if (run) purge(c, t + 2);
                m_act[c] = 1'b0;
                m_idle[c] = ctrl[3];
            end
            default: if (!run) m_idle[c] = ctrl[3];
        endcase
    endtask

    task automatic tick_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] d, input int maxgap, output int unsigned t);
        tick_cycles($urandom_range(maxgap, 0));
        i_data = d;
        i_rx_done_tick = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        i_rx_done_tick = 1'b0;
    endtask

    task automatic send_cmd(input logic [DB-1:0] o, input logic [DB-1:0] f,
                            input logic [7:0] ctrl, input int maxgap, output int unsigned t);
        logic [2*DB+7:0] pl;
        pl = {ctrl, f, o};
        for (int i = 0; i < PN; i++) send_byte(pl[8*i +: 8], maxgap, t);
        model_cmd(o, f, ctrl, t);
    endtask

    // scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        ev_t e;
        int  idx;
        if (!rst_n) begin
            for (int c = 0; c < CHN; c++) begin
                if (o_bit_tick[c] || o_done_tick[c]) begin
                    idx = -1;
                    for (int k = 0; k < sb.size(); k++)
                        if (sb[k].ch == c) begin idx = k; break; end
                    compared++;
                    if (idx < 0) begin
                        mismatched++;
                        $display("FAIL ev ch%0d: unexpected tick=%0b done=%0b at cyc %0d, expected none",
                                 c, o_bit_tick[c], o_done_tick[c], cyc);
                    end else begin
                        e = sb[idx];
                        sb.delete(idx);
                        if (e.cyc != cyc || e.is_done != o_done_tick[c] || e.val != o_serial_out[c]) begin
                            mismatched++;
                            $display("FAIL ev ch%0d: got cyc=%0d done=%0b val=%0b, expected cyc=%0d done=%0b val=%0b",
                                     c, cyc, o_done_tick[c], o_serial_out[c], e.cyc, e.is_done, e.val);
                        end
                    end
                end
            end
            if (o_pkt_err) begin
                compared++;
                if (eq.size() == 0 || cyc < eq[0].lo || cyc > eq[0].hi) begin
                    mismatched++;
                    $display("FAIL pkt_err: pulse at cyc %0d, expected window %0d..%0d",
                             cyc, (eq.size() != 0) ? eq[0].lo : 0, (eq.size() != 0) ? eq[0].hi : 0);
                end
                if (eq.size() != 0) void'(eq.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1);
    end

    initial begin
        int unsigned t, b;
        logic [DB-1:0] ro, rf;
        logic [7:0] ctrl;
        int c;
        bit run;
        err_t er;

        for (int k = 0; k < CHN; k++) begin
            m_act[k] = 0; m_idle[k] = 0; m_mode[k] = 0; m_start[k] = 0; m_len[k] = 0;
        end

        // reset state
        tick_cycles(3);
        chk("rst_serial", int'(o_serial_out), 0);
        chk("rst_bit_tick", int'(o_bit_tick), 0);
        chk("rst_done", int'(o_done_tick), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_pkt_err", int'(o_pkt_err), 0);
        rst_n = 1'b0;
        tick_cycles(3);

        // ch0 one-shot, 32 bits at 4 clocks
        send_cmd(32'h00550055, 32'h0, 8'h01, 2, t);
        wait_until(t + 2);
        chk("t1_busy_run", int'(o_busy[0]), 1);
        wait_until(t + 2 + 128 + 1);
        chk("t1_serial_idle", int'(o_serial_out[0]), 0);
        chk("t1_busy_idle", int'(o_busy[0]), 0);

        // ch1 repeat, mixed speeds, three periods without done
        send_cmd(32'h0000000F, 32'hFFFF0000, 8'h15, 2, t);
        wait_until(t + 2 + 3 * 96 + 10);
        chk("t2_busy", int'(o_busy[1]), 1);

        // ch1 restart at the period boundary
        send_cmd(32'hFFFFFFFF, 32'hFFFF0000, 8'h15, 2, t);
        b = m_start[1];
        wait_until(b + 40);
        chk("t3_serial_new", int'(o_serial_out[1]), 1);
        wait_until(b + 96 + 5);

        // ch1 stop with idle high
        send_cmd(32'h0, 32'h0, 8'h1A, 2, t);
        wait_until(t + 2);
        chk("t4_serial_idle_hi", int'(o_serial_out[1]), 1);
        chk("t4_busy", int'(o_busy[1]), 0);
        tick_cycles(20);

        // partial packet times out
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1, t);
        er.lo = t + TO; er.hi = t + TO + 3;
        eq.push_back(er);
        wait_until(t + TO + 10);
        chk("t5_err_consumed", eq.size(), 0);

        // out-of-range channel is dropped
        send_cmd($urandom, $urandom, 8'h51, 2, t);
        tick_cycles(5);
        chk("t5_bad_ch_serial", int'(o_serial_out), int'(idle_vec()));
        chk("t5_bad_ch_busy", int'(o_busy), 0);

        // randomized commands across channels (including out-of-range ones)
        for (int it = 0; it < 14; it++) begin
            c = $urandom_range(5, 0);
            ro = $urandom;
            rf = $urandom;
            run = (c < CHN) ? running(c, cyc) : 1'b0;
            ctrl = {4'(c), 1'($urandom), 1'($urandom), 2'b01};
            if ($urandom_range(3, 0) == 0) ctrl[1:0] = 2'b10;
            else if (!run && $urandom_range(2, 0) == 0) ctrl[1:0] = 2'b00;
            send_cmd(ro, rf, ctrl, 3, t);
            tick_cycles($urandom_range(150, 0));
        end
        for (int k = 0; k < CHN; k++)
            send_cmd(32'h0, 32'h0, {4'(k), 1'($urandom), 3'b010}, 1, t);
        tick_cycles(5);
        chk("rand_serial_idle", int'(o_serial_out), int'(idle_vec()));
        chk("rand_busy", int'(o_busy), 0);
        chk("rand_sb_empty", sb.size(), 0);

        // reset while ch0 and ch2 run
        send_cmd($urandom, 32'h0, 8'h01, 1, t);
        send_cmd($urandom, 32'h0, 8'h29, 1, t);
        tick_cycles(10);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_serial", int'(o_serial_out), 0);
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_tick", int'(o_bit_tick), 0);
        sb.delete();
        eq.delete();
        for (int k = 0; k < CHN; k++) begin m_act[k] = 0; m_idle[k] = 0; end
        tick_cycles(3);
        rst_n = 1'b0;
        tick_cycles(50);
        chk("post_rst_busy", int'(o_busy), 0);
        chk("post_rst_serial", int'(o_serial_out), 0);
        send_cmd(32'hA5A5A5A5, 32'h0000FFFF, 8'h01, 1, t);
        wait_until(t + 2 + plen(32'h0000FFFF) + 3);
        chk("final_sb_empty", sb.size(), 0);
        chk("final_err_empty", eq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multi_ch_pattern_gen.md
Name: multi_ch_pattern_gen

Overview:
Parametrised successor to the single-generation differential-frequency serial output block. It receives UART byte packets, assembles per-channel output and frequency patterns, and drives CH_NUM independent serial outputs. Each pattern bit is held for a low- or high-speed duration, selected per bit. New over the previous generation: parametric width and channel count, double-buffered seamless pattern update, a stop command, a packet timeout and per-channel status.

Parameters:
DATA_BIT, 32, pattern width in bits; multiple of 8, range 8..64.
CH_NUM, 16, number of output channels, range 1..16.
LOW_DIV, 20, clocks per bit when the freq bit is 0; must be >= 2.
HIGH_DIV, 5, clocks per bit when the freq bit is 1; must be >= 2.
TIMEOUT, 100000, idle clocks between bytes before a partial packet is discarded.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-high
i_data  in  8  received UART byte
i_rx_done_tick  in  1  one-clock strobe; i_data valid this cycle
o_serial_out  out  CH_NUM  serial outputs
o_bit_tick  out  CH_NUM  one-clock pulse on the first cycle of each driven bit
o_done_tick  out  CH_NUM  one-clock pulse when a one-shot pattern completes
o_busy  out  CH_NUM  channel running
o_pkt_err  out  1  one-clock pulse on timeout or bad packet

Behaviour:
- Reset (rst_n=1, async): all outputs 0, all channel shadow/active registers 0, idle level 0, assembler byte count 0.
- Packet: PACK_NUM = 2*DATA_BIT/8+1 bytes (localparam), sent in this order:
  - out pattern, LSB byte first;
  - freq pattern, LSB byte first;
  - control byte: [7:4] channel, [3] idle level, [2] mode (0 one-shot, 1 repeat), [1:0] cmd (00 load, 01 start, 10 stop, 11 ignored).
- Assembler:
  - Counts bytes on i_rx_done_tick.
  - Timer resets on every byte; it counts only while the byte count is non-zero.
  - Timer reaching TIMEOUT: count cleared, o_pkt_err pulses, nothing written.
  - On the final byte (cycle T): channel >= CH_NUM -> o_pkt_err pulses at T+1, packet dropped. Otherwise patterns, idle level and mode are written to that channel's shadow at T+1, together with a cmd strobe.
- Channel FSM: IDLE, RUN.
  - IDLE: output = idle level, o_busy=0.
  - IDLE + start strobe at T+1: shadow copied to active; bit 0 driven from T+2; o_bit_tick pulses at T+2.
  - RUN: bits are sent LSB first. Bit i is held HIGH_DIV clocks if freq[i]=1, else LOW_DIV clocks.
  - After bit DATA_BIT-1, one-shot: output returns to idle level next cycle, o_done_tick pulses on that cycle, state -> IDLE.
  - After bit DATA_BIT-1, repeat: wraps to bit 0 with no gap cycle.
- Start while RUN: pending flag set. At the next pattern boundary (where bit 0 would begin), shadow is copied to active and the new pattern starts with no gap. One-shot completion is then suppressed: no done tick, the channel stays RUN.
- Stop strobe: from the next cycle the output = idle level, state IDLE, pending cleared, no done tick. Stop in IDLE only updates the idle level.
- Load: updates the shadow only; it is consumed by the next start. A load in RUN does not set pending.
- Idle level written by any command takes effect immediately when the channel is IDLE. When the channel is RUN, it takes effect at the next copy or stop.
- Byte strobe coinciding with timeout expiry: the byte is counted as byte 0 of a new packet.
- Bit counter width: $clog2(DATA_BIT). Divider counter width covers max(LOW_DIV, HIGH_DIV).

Decomposition:
- Package multi_ch_pattern_pkg holds:
  - cmd encodings CMD_LOAD/START/STOP;
  - control-byte field positions;
  - the PACK_NUM function;
  - channel state enum IDLE/RUN.
- One sub-module, pattern_ch_runner: shadow/active registers, pending flag, divider, bit counter and FSM. It is instantiated CH_NUM times by a generate loop. The top level holds only the assembler, timer and channel decode.

Test Plan:
Bench settings: DATA_BIT=32, CH_NUM=4, LOW_DIV=4, HIGH_DIV=2, TIMEOUT=200.
- Ch0 one-shot: out 32'h00550055, freq 0, control 8'h01 -> ch0 drives 0x55 pattern LSB first, each bit 4 clocks, 32 bit ticks. After the last bit: one done tick, then output 0, o_busy 0.
- Ch1 repeat: out 32'h0000000F, freq 32'hFFFF0000, control 8'h15 -> bits 0-15 at 4 clocks, bits 16-31 at 2 clocks. Pattern wraps with no gap; no done tick over 3 periods.
- Ch1 running, then start with out 32'hFFFFFFFF -> the old pattern finishes its period, and the new pattern begins at the exact boundary cycle.
- Ch1 running, control 8'h1A (stop, idle high) -> ch1 is 1 the cycle after the strobe, o_busy 0, no done tick.
- Send 5 bytes then idle 200 clocks -> o_pkt_err pulses once. A following full packet with control 8'h51 (channel 5) -> o_pkt_err pulses, and all outputs are unchanged.
- Assert rst_n mid-RUN on ch0 and ch2 -> all outputs 0 immediately. After release a start is required to run again.
